// File: rtl/stream_pkg.sv
// Shared stream definitions: packer state encoding and default beat geometry
// used by the stream source, packer and verification agents.
package stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_BEATS  = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pack_state_t;

  // Beat counter width; a single-beat packer still needs a 1-bit counter.
  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready output holding register for packed words: loads on a word close,
// holds while the consumer stalls, drops m_valid once the word is taken.
module stream_out_reg #(
  parameter int DATA_W = 8,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DATA_W*BEATS-1:0]   load_data,
  input  logic [BEATS-1:0]          load_keep,
  input  logic                      load_last,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic [DATA_W*BEATS-1:0]   m_data,
  output logic [BEATS-1:0]          m_keep,
  output logic                      m_last
);

  // A load only happens while the slot is empty or being drained, so it
  // never overwrites an unconsumed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_beat_packer.sv
// Packs BEATS narrow valid/ready beats into one wide word, closing early on
// s_last and flagging populated byte lanes in m_keep.
module stream_beat_packer
  import stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W*BEATS-1:0]   m_data,
  output logic [BEATS-1:0]          m_keep,
  output logic                      m_last
);

  localparam int OUT_W = DATA_W * BEATS;
  localparam int CW    = cnt_w(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  pack_state_t                    state_p0;
  logic [CW-1:0]                  cnt_p0;
  logic [BEATS-1:0][DATA_W-1:0]   acc_p0;
  logic [BEATS-1:0]               keep_p0;

  logic                           in_fire;
  logic                           close;
  logic [BEATS-1:0][DATA_W-1:0]   word_nxt;
  logic [BEATS-1:0]               keep_nxt;
  logic [OUT_W-1:0]               word_flat;

  // HOLD means the output slot is full, so this matches !m_valid || m_ready.
  assign s_ready = (state_p0 == COLLECT) || m_ready;
  assign in_fire = s_valid && s_ready;
  assign close   = in_fire && ((cnt_p0 == LAST_IDX) || s_last);

  always_comb begin
    word_nxt = acc_p0;
    keep_nxt = keep_p0;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_p0 == CW'(k)) begin
        word_nxt[k] = s_data;
        keep_nxt[k] = 1'b1;
      end
    end
  end

  assign word_flat = word_nxt;

  // Stage p0: beat accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0  <= '0;
      acc_p0  <= '0;
      keep_p0 <= '0;
    end else if (close) begin
      cnt_p0  <= '0;
      acc_p0  <= '0;
      keep_p0 <= '0;
    end else if (in_fire) begin
      cnt_p0  <= cnt_p0 + CW'(1);
      acc_p0  <= word_nxt;
      keep_p0 <= keep_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= COLLECT;
    end else begin
      case (state_p0)
        COLLECT: if (close) state_p0 <= HOLD;
        HOLD:    if (m_ready && !close) state_p0 <= COLLECT;
        default: state_p0 <= COLLECT;
      endcase
    end
  end

  // Stage p1: output holding register
  stream_out_reg #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (close),
    .load_data (word_flat),
    .load_keep (keep_nxt),
    .load_last (s_last),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last)
  );

endmodule
